// File: rtl/psram_pixel_writer.sv
// rtl/psram_pixel_writer.sv - turns (x, y, colour) pixel writes into asynchronous Cellular RAM byte writes
module psram_pixel_writer #(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter logic [25:0] BASE_ADDR    = 26'h0,
  parameter int          SETUP_CYCLES = 1,
  parameter int          WE_CYCLES    = 4,
  parameter int          HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [7:0]  wr_pixel,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [25:0] MemAdr,
  output logic [15:0] MemDB_out,
  output logic        MemDB_oe,
  output logic        MemOE,
  output logic        MemWR,
  output logic        RamCS,
  output logic        RamAdv,
  output logic        RamCRE,
  output logic        RamClk,
  output logic        RamLB,
  output logic        RamUB,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, REQ, SETUP, WRITE, HOLD} stateType;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WE_LAST    = 8'(WE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  stateType    state, nextState;
  logic [7:0]  phaseCnt, nextPhaseCnt;
  logic [25:0] pendAdr;
  logic        pendHigh;
  logic [7:0]  pendPixel;
  logic [18:0] inIndex;
  logic [25:0] inAdr;
  logic        inRange;
  logic        accept;
  logic        driveNext;
  logic        enterSetup;

  // The part is only ever used in asynchronous mode and never read from here
  assign MemOE  = 1'b1;
  assign RamAdv = 1'b0;
  assign RamCRE = 1'b0;
  assign RamClk = 1'b0;

  // Decode the offered request: frame index, word address and range check
  always_comb begin
    inIndex = 19'(wr_y) * 19'(H_RES) + 19'(wr_x);
    inAdr   = BASE_ADDR + {8'd0, inIndex[18:1]};
    inRange = (32'(wr_x) < 32'(H_RES)) && (32'(wr_y) < 32'(V_RES));
    accept  = wr_valid && wr_ready;
  end

  // Next-state logic; each bus phase is timed by phaseCnt, restarted on phase entry
  always_comb begin
    nextState    = state;
    nextPhaseCnt = phaseCnt;
    case (state)
      IDLE: begin
        if (accept && inRange) nextState = REQ;
      end
      REQ: begin
        if (bus_gnt) begin
          nextState    = SETUP;
          nextPhaseCnt = '0;
        end
      end
      SETUP: begin
        if (phaseCnt == SETUP_LAST) begin
          nextState    = WRITE;
          nextPhaseCnt = '0;
        end else begin
          nextPhaseCnt = phaseCnt + 8'd1;
        end
      end
      WRITE: begin
        if (phaseCnt == WE_LAST) begin
          nextState    = HOLD;
          nextPhaseCnt = '0;
        end else begin
          nextPhaseCnt = phaseCnt + 8'd1;
        end
      end
      HOLD: begin
        if (phaseCnt == HOLD_LAST) begin
          nextPhaseCnt = '0;
          nextState    = (accept && inRange) ? SETUP : IDLE;
        end else begin
          nextPhaseCnt = phaseCnt + 8'd1;
        end
      end
      default: nextState = IDLE;
    endcase
    driveNext  = (nextState == SETUP) || (nextState == WRITE) || (nextState == HOLD);
    enterSetup = (nextState == SETUP) && (state != SETUP);
  end

  // State, phase counter and the request parked while waiting for the grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      pendAdr   <= '0;
      pendHigh  <= 1'b0;
      pendPixel <= '0;
    end else begin
      state    <= nextState;
      phaseCnt <= nextPhaseCnt;
      if (state == IDLE && accept) begin
        pendAdr   <= inAdr;
        pendHigh  <= inIndex[0];
        pendPixel <= wr_pixel;
      end
    end
  end

  // Handshake and bus control strobes, registered from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ready <= 1'b0;
      bus_req  <= 1'b0;
      err      <= 1'b0;
      RamCS    <= 1'b1;
      MemDB_oe <= 1'b0;
      MemWR    <= 1'b1;
    end else begin
      wr_ready <= (nextState == IDLE) || (nextState == HOLD && nextPhaseCnt == HOLD_LAST);
      bus_req  <= (nextState != IDLE);
      err      <= accept && !inRange;
      RamCS    <= !driveNext;
      MemDB_oe <= driveNext;
      MemWR    <= (nextState != WRITE);
    end
  end

  // Address, data and byte enables load only on entry to SETUP; enables drop when the bus is released
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MemAdr    <= '0;
      MemDB_out <= '0;
      RamLB     <= 1'b1;
      RamUB     <= 1'b1;
    end else if (enterSetup) begin
      if (state == HOLD) begin
        MemAdr    <= inAdr;
        MemDB_out <= {wr_pixel, wr_pixel};
        RamLB     <= inIndex[0];
        RamUB     <= !inIndex[0];
      end else begin
        MemAdr    <= pendAdr;
        MemDB_out <= {pendPixel, pendPixel};
        RamLB     <= pendHigh;
        RamUB     <= !pendHigh;
      end
    end else if (!driveNext) begin
      RamLB <= 1'b1;
      RamUB <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psram_pixel_writer.sv
// tb/tb_psram_pixel_writer.sv - directed vectors and corner sequences for psram_pixel_writer
module tb_psram_pixel_writer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_valid = 1'b0;
  logic [9:0]  wr_x = '0;
  logic [8:0]  wr_y = '0;
  logic [7:0]  wr_pixel = '0;
  logic        bus_gnt = 1'b0;
  logic        wr_ready, bus_req, MemDB_oe, MemOE, MemWR, RamCS;
  logic        RamAdv, RamCRE, RamClk, RamLB, RamUB, err;
  logic [25:0] MemAdr;
  logic [15:0] MemDB_out;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  pix;
    logic [25:0] adr;
    logic        ub;
    logic        lb;
  } vecType;

  vecType vecs [7];

  psram_pixel_writer dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .MemAdr(MemAdr), .MemDB_out(MemDB_out), .MemDB_oe(MemDB_oe),
    .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS),
    .RamAdv(RamAdv), .RamCRE(RamCRE), .RamClk(RamClk),
    .RamLB(RamLB), .RamUB(RamUB), .err(err)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request and return just after the edge that accepted it
  task automatic sendReq(input logic [9:0] x, input logic [8:0] y, input logic [7:0] p);
    bit ok;
    ok = 1'b0;
    wr_x = x; wr_y = y; wr_pixel = p; wr_valid = 1'b1;
    for (int b = 0; b < 50 && !ok; b++) begin
      ok = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic waitIdle();
    for (int b = 0; b < 30 && bus_req; b++) tick();
    check("idle timeout", bus_req, 0);
  endtask

  // Single write with grant held high; k=0 is the REQ clock after the accept edge
  task automatic runVector(input int i);
    logic [7:0]  wrPat, csPat, reqPat, rdyPat;
    logic [25:0] adr0;
    int          adrMoves;
    adrMoves = 0;
    adr0 = '0;
    sendReq(vecs[i].x, vecs[i].y, vecs[i].pix);
    for (int k = 0; k < 8; k++) begin
      wrPat[k] = MemWR; csPat[k] = RamCS; reqPat[k] = bus_req; rdyPat[k] = wr_ready;
      if (k == 1) begin
        check($sformatf("v%0d adr", i), MemAdr, vecs[i].adr);
        check($sformatf("v%0d data", i), MemDB_out, {vecs[i].pix, vecs[i].pix});
        check($sformatf("v%0d ub/lb", i), {RamUB, RamLB}, {vecs[i].ub, vecs[i].lb});
        check($sformatf("v%0d oe", i), MemDB_oe, 1);
        adr0 = MemAdr;
      end
      if (k >= 2 && k <= 6 && MemAdr !== adr0) adrMoves++;
      tick();
    end
    check($sformatf("v%0d MemWR pattern", i), wrPat, 8'b1100_0011);
    check($sformatf("v%0d RamCS pattern", i), csPat, 8'b1000_0001);
    check($sformatf("v%0d bus_req pattern", i), reqPat, 8'b0111_1111);
    check($sformatf("v%0d wr_ready pattern", i), rdyPat, 8'b1100_0000);
    check($sformatf("v%0d adr stable", i), adrMoves, 0);
  endtask

  initial begin
    int f1, f2, csHigh, bad, errCnt, busy, notReady;
    logic prevWr, dropNext;

    vecs[0] = '{10'd3,   9'd2,   8'hE0, 26'h281,   1'b0, 1'b1};
    vecs[1] = '{10'd0,   9'd0,   8'h5A, 26'h0,     1'b1, 1'b0};
    vecs[2] = '{10'd639, 9'd479, 8'hFF, 26'h257FF, 1'b0, 1'b1};
    vecs[3] = '{10'd1,   9'd0,   8'h12, 26'h0,     1'b0, 1'b1};
    vecs[4] = '{10'd638, 9'd0,   8'h34, 26'h13F,   1'b1, 1'b0};
    vecs[5] = '{10'd0,   9'd1,   8'h81, 26'h140,   1'b1, 1'b0};
    vecs[6] = '{10'd100, 9'd200, 8'hC3, 26'hFA32,  1'b1, 1'b0};

    // Reset values
    tick(); tick();
    check("rst MemWR", MemWR, 1);
    check("rst MemOE", MemOE, 1);
    check("rst RamCS", RamCS, 1);
    check("rst ub/lb", {RamUB, RamLB}, 2'b11);
    check("rst oe", MemDB_oe, 0);
    check("rst bus_req", bus_req, 0);
    check("rst err", err, 0);
    check("rst adr", MemAdr, 0);
    check("rst data", MemDB_out, 0);
    check("rst adv/cre/clk", {RamAdv, RamCRE, RamClk}, 0);
    check("rst wr_ready", wr_ready, 0);
    resetn = 1'b1;
    check("release wr_ready before edge", wr_ready, 0);
    tick();
    check("release wr_ready", wr_ready, 1);

    // Table-driven writes with a continuous grant
    bus_gnt = 1'b1;
    for (int i = 0; i < 7; i++) runVector(i);

    // Reset in the middle of WRITE
    sendReq(10'd5, 9'd5, 8'h11);
    tick(); tick();
    check("mid write MemWR low", MemWR, 0);
    resetn = 1'b0;
    #1;
    check("async rst MemWR", MemWR, 1);
    check("async rst RamCS", RamCS, 1);
    check("async rst bus_req", bus_req, 0);
    check("async rst oe", MemDB_oe, 0);
    check("async rst wr_ready", wr_ready, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("post rst wr_ready", wr_ready, 1);
    runVector(0);

    // Back-to-back: (0,0) then (639,479) accepted in the last HOLD clock
    sendReq(10'd0, 9'd0, 8'h3C);
    wr_x = 10'd639; wr_y = 9'd479; wr_pixel = 8'hA5; wr_valid = 1'b1;
    f1 = -1; f2 = -1; csHigh = 0; prevWr = 1'b1; dropNext = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (dropNext) begin wr_valid = 1'b0; dropNext = 1'b0; end
      if (!MemWR && prevWr) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
      prevWr = MemWR;
      if (k >= 1 && k <= 12 && RamCS) csHigh++;
      if (k == 3) begin
        check("b2b first adr", MemAdr, 0);
        check("b2b first ub/lb", {RamUB, RamLB}, 2'b10);
      end
      if (k == 9) begin
        check("b2b second adr", MemAdr, 26'h257FF);
        check("b2b second ub/lb", {RamUB, RamLB}, 2'b01);
        check("b2b second data", MemDB_out, 16'hA5A5);
      end
      if (k == 13) check("b2b released", RamCS, 1);
      if (wr_valid && wr_ready) dropNext = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    check("b2b first fall", f1, 2);
    check("b2b fall spacing", f2 - f1, 6);
    check("b2b RamCS held low", csHigh, 0);

    // Grant withheld for 20 clocks
    bus_gnt = 1'b0;
    sendReq(10'd10, 9'd10, 8'h77);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus_req || !RamCS || !MemWR || MemDB_oe) bad++;
      tick();
    end
    check("no grant bus idle", bad, 0);
    bus_gnt = 1'b1;
    check("grant pending RamCS", RamCS, 1);
    tick();
    check("grant SETUP RamCS", RamCS, 0);
    check("grant SETUP MemWR", MemWR, 1);
    check("grant SETUP adr", MemAdr, 26'hC85);
    tick();
    check("grant WRITE MemWR", MemWR, 0);
    waitIdle();

    // Out-of-range requests are dropped with one err pulse each
    for (int t = 0; t < 2; t++) begin
      if (t == 0) sendReq(10'd640, 9'd10, 8'h01);
      else        sendReq(10'd5, 9'd480, 8'h02);
      errCnt = 0; busy = 0; notReady = 0;
      for (int k = 0; k < 4; k++) begin
        if (err) errCnt++;
        if (bus_req || !MemWR || !RamCS) busy++;
        if (!wr_ready) notReady++;
        tick();
      end
      check($sformatf("oor%0d err pulses", t), errCnt, 1);
      check($sformatf("oor%0d bus untouched", t), busy, 0);
      check($sformatf("oor%0d wr_ready held", t), notReady, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/psram_pixel_writer.md
# psram_pixel_writer

Write-side companion to the VGA frame reader. It takes pixel writes (x, y, 8-bit RRRGGGBB colour) over a valid/ready handshake and turns each one into an asynchronous byte write to the Cellular RAM frame buffer. The frame buffer is 640x480 at 8 bpp, two pixels per 16-bit word. The block sits beside the scan-out reader on the shared MemAdr/MemDB/Ram* bus and owns that bus only while an external arbiter grants it.

## Interface
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- BASE_ADDR, 26'h0, word address of pixel (0,0)
- SETUP_CYCLES, 1, clocks with RamCS low and address/data valid before MemWR falls (≥1)
- WE_CYCLES, 4, clocks MemWR is held low (≥1; 4 clocks = 80 ns at 50 MHz, meets tWC/tWP)
- HOLD_CYCLES, 1, clocks with MemWR high and address/data held after MemWR rises (≥1)

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  block can accept a request
- wr_x  in  10  column
- wr_y  in  9  row
- wr_pixel  in  8  colour, RRRGGGBB
- bus_req  out  1  request for the memory bus
- bus_gnt  in  1  arbiter grant; must stay high until bus_req falls
- MemAdr  out  26  word address, bits [26:1]
- MemDB_out  out  16  write data
- MemDB_oe  out  1  tri-state enable for MemDB at top level
- MemOE  out  1  output enable, active low, tied high
- MemWR  out  1  write enable, active low
- RamCS  out  1  chip select, active low
- RamAdv  out  1  address valid, held 0 (asynchronous mode)
- RamCRE  out  1  configuration register enable, held 0
- RamClk  out  1  held 0
- RamLB  out  1  lower byte enable, active low
- RamUB  out  1  upper byte enable, active low
- err  out  1  one-cycle pulse when an out-of-range write is dropped

## Operation
- States and transitions:
  - IDLE: wr_ready=1. On wr_valid with wr_x<H_RES and wr_y<V_RES, capture the request and go to REQ. If either coordinate is out of range, accept the request, pulse err, and stay in IDLE.
  - REQ: bus_req=1, wr_ready=0. Wait for bus_gnt=1 sampled at a clock edge, then go to SETUP.
  - SETUP: RamCS=0, MemAdr, byte enables and MemDB_out valid, MemDB_oe=1, MemWR=1. Lasts SETUP_CYCLES, then WRITE.
  - WRITE: as SETUP, but MemWR=0. Lasts WE_CYCLES, then HOLD.
  - HOLD: as SETUP, with MemWR=1. Lasts HOLD_CYCLES. wr_ready=1 in the last HOLD clock only.
    - Valid in-range accept in that clock: go straight to SETUP with the new request. bus_req stays high and RamCS stays low.
    - Out-of-range accept: pulse err and go to IDLE.
    - No accept: go to IDLE.
  - Entering IDLE: bus_req=0, RamCS=1, MemDB_oe=0, RamLB=RamUB=1.
- Address arithmetic:
  - index = wr_y*H_RES + wr_x, 19 bits unsigned.
  - MemAdr = BASE_ADDR + index[18:1], 26 bits, wraps modulo 2^26.
  - index[0]=0 selects the low byte: RamLB=0, RamUB=1.
  - index[0]=1 selects the high byte: RamUB=0, RamLB=1.
- Data: MemDB_out = {wr_pixel, wr_pixel}; the byte enables choose which byte is written.
- Grant handling:
  - bus_gnt falling during SETUP/WRITE/HOLD is ignored; the write cycle completes. Revoking the grant there is an arbiter protocol violation.
  - The block never drives the bus in IDLE or REQ.
- All outputs are registered; no combinational path from inputs to Mem*/Ram*.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - MemWR=1, MemOE=1, RamCS=1, RamLB=RamUB=1, MemDB_oe=0, bus_req=0, err=0.
  - RamAdv=0, RamCRE=0, RamClk=0, MemAdr=0, MemDB_out=0.
  - wr_ready=0 while resetn=0, and 1 from the first clock after release.
  - An in-flight write is abandoned. MemWR rises asynchronously with reset; partial-write content is undefined.

## Timing
- Accept at edge T: bus_req=1 after T.
- With bus_gnt already high at T+1:
  - SETUP starts at T+1.
  - MemWR falls at T+1+SETUP_CYCLES and is low for exactly WE_CYCLES clocks.
- Back-to-back in-range writes with a continuous grant: one write per SETUP_CYCLES+WE_CYCLES+HOLD_CYCLES clocks. This is 6 clocks with the defaults. RamCS stays low throughout.
- MemAdr, MemDB_out and the byte enables change only on entry to SETUP. They are stable for the whole time MemWR is low, plus at least one clock on each side of it.
- err is high for exactly one clock per dropped request.

## Test plan
- Reset mid-WRITE (resetn low 2 cycles) → MemWR=1 and RamCS=1 immediately, bus_req=0. After release, wr_ready=1 and a new write completes normally.
- bus_gnt=1, write x=3,y=2,pixel=8'hE0 → MemAdr=26'h281, RamUB=0, RamLB=1, MemDB_out=16'hE0E0. MemWR is low exactly 4 clocks, starting 1 clock after RamCS falls.
- x=0,y=0 then immediately x=639,y=479 (BASE_ADDR=0), grant held:
  - First write: MemAdr=0, RamLB=0.
  - Second write: MemAdr=26'h257FF, RamUB=0.
  - RamCS stays low between them; the two MemWR low pulses are 6 clocks apart.
- bus_gnt held 0 for 20 clocks after accept → bus_req=1, RamCS=1, MemWR=1 throughout. SETUP starts on the first edge with bus_gnt=1.
- Write x=640,y=10 and x=5,y=480 → one err pulse per request. No bus_req, no MemWR activity, wr_ready stays 1.
